// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF-stage PC register with sequential/branch/jump next-PC select,
// stall hold and IF/ID flush generation.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [15:0] branch_imm_i,
  input  logic        jump_i,
  input  logic [25:0] jump_addr_i,
  input  logic [31:0] id_pc_plus4_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        flush_o,
  output logic        valid_o,
  output logic [31:0] fetch_cnt_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]  state;
  logic [31:0] pc, cnt, next_pc, br_target, j_target;
  logic        run, advance;
  assign run        = state == RUN;
  assign advance    = run & ~stall_i;
  assign j_target   = {id_pc_plus4_i[31:28], jump_addr_i, 2'b00};
  assign br_target  = id_pc_plus4_i + {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};
  // jump outranks branch when ID resolves both in the same cycle
  always_comb next_pc = jump_i ? j_target : branch_i ? br_target : pc + PC_STEP;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      cnt   <= '0;
    end else begin
      if (!run && start_i) state <= RUN;
      if (advance) begin
        pc  <= next_pc;
        cnt <= cnt + 32'd1;
      end
    end
  end
  assign pc_o        = pc;
  assign pc_plus4_o  = pc + PC_STEP;
  assign flush_o     = advance & (jump_i | branch_i);
  assign valid_o     = run;
  assign fetch_cnt_o = cnt;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized run against a
// behavioural next-PC model.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, stall_i = 1'b0, branch_i = 1'b0, jump_i = 1'b0;
  logic [15:0] branch_imm_i = '0;
  logic [25:0] jump_addr_i = '0;
  logic [31:0] id_pc_plus4_i = '0;
  logic [31:0] pc_o, pc_plus4_o, fetch_cnt_o;
  logic        flush_o, valid_o;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stall_i(stall_i),
    .branch_i(branch_i), .branch_imm_i(branch_imm_i), .jump_i(jump_i),
    .jump_addr_i(jump_addr_i), .id_pc_plus4_i(id_pc_plus4_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .flush_o(flush_o),
    .valid_o(valid_o), .fetch_cnt_o(fetch_cnt_o)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  logic        m_run = 1'b0;
  logic [31:0] m_pc = 32'h0, m_cnt = 32'h0;
  logic        obs_flush, exp_flush;
  logic [31:0] obs_p4, exp_p4;

  // Applies one cycle of inputs (called just after a falling edge), samples the
  // combinational outputs before the rising edge, then advances the model.
  task automatic drive(input logic s, input logic st, input logic br, input logic jp,
                       input logic [15:0] imm, input logic [25:0] ja, input logic [31:0] idp);
    start_i = s; stall_i = st; branch_i = br; jump_i = jp;
    branch_imm_i = imm; jump_addr_i = ja; id_pc_plus4_i = idp;
    #1;
    obs_flush = flush_o; obs_p4 = pc_plus4_o;
    exp_flush = m_run & ~st & (jp | br);
    exp_p4    = m_pc + 32'd4;
    @(posedge clk);
    if (!m_run) begin
      if (s) m_run = 1'b1;
    end else if (!st) begin
      if (jp)      m_pc = {idp[31:28], ja, 2'b00};
      else if (br) m_pc = idp + 32'($signed(imm)) * 32'd4;
      else         m_pc = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; branch_i = 1'b1; jump_i = 1'b1; stall_i = 1'b0; start_i = 1'b0;
    #1;
    total++; if (pc_o !== 32'h0) $display("FAIL reset_pc got %h exp %h", pc_o, 32'h0); else passed++;
    total++; if (pc_plus4_o !== 32'h4) $display("FAIL reset_pc4 got %h exp %h", pc_plus4_o, 32'h4); else passed++;
    total++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid_o); else passed++;
    total++; if (flush_o !== 1'b0) $display("FAIL reset_flush got %b exp 0", flush_o); else passed++;
    total++; if (fetch_cnt_o !== 32'h0) $display("FAIL reset_cnt got %h exp 0", fetch_cnt_o); else passed++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; branch_i = 1'b0; jump_i = 1'b0;
    m_run = 1'b0; m_pc = 32'h0; m_cnt = 32'h0;
  endtask

  task automatic test_startup;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, $urandom_range(0, 1), 1'b1, 1'(k), 16'($urandom), 26'($urandom), $urandom);
      total++; if (obs_flush !== 1'b0) $display("FAIL idle_flush got %b exp 0", obs_flush); else passed++;
      total++; if (pc_o !== 32'h0 || valid_o !== 1'b0) $display("FAIL idle_hold got pc=%h valid=%b exp pc=0 valid=0", pc_o, valid_o); else passed++;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    total++; if (pc_o !== 32'h0 || valid_o !== 1'b1 || fetch_cnt_o !== 32'h0)
      $display("FAIL start_first got pc=%h valid=%b cnt=%0d exp pc=0 valid=1 cnt=0", pc_o, valid_o, fetch_cnt_o); else passed++;
    for (int k = 1; k <= 3; k++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
      total++; if (pc_o !== 32'(4 * k) || fetch_cnt_o !== 32'(k))
        $display("FAIL seq_%0d got pc=%h cnt=%0d exp pc=%h cnt=%0d", k, pc_o, fetch_cnt_o, 32'(4 * k), k); else passed++;
    end
  endtask

  task automatic test_stall;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    total++; if (pc_o !== 32'h10) $display("FAIL pre_stall_pc got %h exp 10", pc_o); else passed++;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 26'($urandom), $urandom);
      total++; if (obs_flush !== 1'b0) $display("FAIL stall_flush got %b exp 0", obs_flush); else passed++;
      total++; if (pc_o !== 32'h10 || fetch_cnt_o !== 32'd4)
        $display("FAIL stall_hold got pc=%h cnt=%0d exp pc=10 cnt=4", pc_o, fetch_cnt_o); else passed++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    total++; if (pc_o !== 32'h14 || fetch_cnt_o !== 32'd5)
      $display("FAIL stall_release got pc=%h cnt=%0d exp pc=14 cnt=5", pc_o, fetch_cnt_o); else passed++;
  endtask

  task automatic test_branch;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE, 26'h0, 32'h0000_000C);
    total++; if (obs_flush !== 1'b1) $display("FAIL branch_back_flush got %b exp 1", obs_flush); else passed++;
    total++; if (pc_o !== 32'h4) $display("FAIL branch_back_pc got %h exp 4", pc_o); else passed++;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 26'h0, 32'h0000_000C);
    total++; if (obs_flush !== 1'b1) $display("FAIL branch_fwd_flush got %b exp 1", obs_flush); else passed++;
    total++; if (pc_o !== 32'h18) $display("FAIL branch_fwd_pc got %h exp 18", pc_o); else passed++;
  endtask

  task automatic test_jump;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'($urandom), 26'h0000040, 32'hA000_0010);
    total++; if (obs_flush !== 1'b1) $display("FAIL jump_flush got %b exp 1", obs_flush); else passed++;
    total++; if (pc_o !== 32'hA000_0100) $display("FAIL jump_pc got %h exp a0000100", pc_o); else passed++;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'($urandom), 26'h0000040, 32'hA000_0010);
    total++; if (obs_flush !== 1'b0) $display("FAIL jump_stall_flush got %b exp 0", obs_flush); else passed++;
    total++; if (pc_o !== 32'hA000_0100 || fetch_cnt_o !== 32'd8)
      $display("FAIL jump_stall_hold got pc=%h cnt=%0d exp pc=a0000100 cnt=8", pc_o, fetch_cnt_o); else passed++;
  endtask

  task automatic test_wrap;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h3FF_FFFF, 32'hF000_0000);
    total++; if (pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_setup got %h exp fffffffc", pc_o); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    total++; if (obs_p4 !== 32'h0) $display("FAIL wrap_pc4 got %h exp 0", obs_p4); else passed++;
    total++; if (pc_o !== 32'h0) $display("FAIL wrap_pc got %h exp 0", pc_o); else passed++;
  endtask

  task automatic test_random;
    for (int k = 0; k < 200; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0,
            $urandom_range(0, 6) == 0, 16'($urandom), 26'($urandom), $urandom);
      total++; if (obs_flush !== exp_flush) $display("FAIL rnd_flush[%0d] got %b exp %b", k, obs_flush, exp_flush); else passed++;
      total++; if (obs_p4 !== exp_p4) $display("FAIL rnd_pc4[%0d] got %h exp %h", k, obs_p4, exp_p4); else passed++;
      total++; if (pc_o !== m_pc) $display("FAIL rnd_pc[%0d] got %h exp %h", k, pc_o, m_pc); else passed++;
      total++; if (fetch_cnt_o !== m_cnt) $display("FAIL rnd_cnt[%0d] got %0d exp %0d", k, fetch_cnt_o, m_cnt); else passed++;
      total++; if (valid_o !== m_run) $display("FAIL rnd_valid[%0d] got %b exp %b", k, valid_o, m_run); else passed++;
    end
  endtask

  task automatic test_async_reset;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h10, 32'h0);
    total++; if (pc_o !== 32'h40) $display("FAIL areset_setup got %h exp 40", pc_o); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (pc_o !== 32'h0 || valid_o !== 1'b0 || fetch_cnt_o !== 32'h0)
      $display("FAIL areset_now got pc=%h valid=%b cnt=%0d exp pc=0 valid=0 cnt=0", pc_o, valid_o, fetch_cnt_o); else passed++;
    m_run = 1'b0; m_pc = 32'h0; m_cnt = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'($urandom), 26'($urandom), $urandom);
      total++; if (pc_o !== 32'h0 || valid_o !== 1'b0 || obs_flush !== 1'b0)
        $display("FAIL areset_idle got pc=%h valid=%b flush=%b exp 0/0/0", pc_o, valid_o, obs_flush); else passed++;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    total++; if (pc_o !== 32'h0 || valid_o !== 1'b1) $display("FAIL areset_restart got pc=%h valid=%b exp pc=0 valid=1", pc_o, valid_o); else passed++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    total++; if (pc_o !== 32'h4 || fetch_cnt_o !== 32'd1)
      $display("FAIL areset_resume got pc=%h cnt=%0d exp pc=4 cnt=1", pc_o, fetch_cnt_o); else passed++;
  endtask

  initial begin
    test_reset;
    test_startup;
    test_stall;
    test_branch;
    test_jump;
    test_wrap;
    test_random;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- IF-stage program-counter and fetch-control block, sitting directly upstream of the IF/ID pipeline register.
- Holds the PC and drives the instruction-memory address.
- Supplies PC+4 to IF/ID's PC input.
- Resolves next-PC from sequential, branch and jump sources, honours hazard-detection stalls, and generates the flush that squashes the wrong-path instruction in IF/ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset and held while idle.
- PC_STEP, 4, byte increment for sequential fetch.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  level; enables fetching (IDLE->RUN).
- stall_i  input  1  hazard-detection hold (same signal that drives IF/ID HD input).
- branch_i  input  1  taken branch resolved in ID this cycle.
- branch_imm_i  input  16  branch offset in words, signed.
- jump_i  input  1  unconditional jump resolved in ID this cycle.
- jump_addr_i  input  26  jump target field.
- id_pc_plus4_i  input  32  PC+4 of the instruction currently in ID (IF/ID address output).
- pc_o  output  32  instruction-memory address.
- pc_plus4_o  output  32  pc_o + PC_STEP, to IF/ID.
- flush_o  output  1  squash IF/ID contents (to an IF/ID flush input).
- valid_o  output  1  high in RUN: the fetched instruction is meaningful.
- fetch_cnt_o  output  32  count of PC updates performed in RUN.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-run):
  - pc_o=RESET_PC, state=IDLE, fetch_cnt_o=0.
  - valid_o=0, flush_o=0; pc_plus4_o=RESET_PC+PC_STEP.
- States: IDLE, RUN. Registered state.
  - IDLE: pc held at RESET_PC; all redirect/stall inputs ignored; flush_o=0. start_i=1 at a rising edge -> RUN next cycle. PC is not advanced on that edge, so the first RUN cycle fetches RESET_PC.
  - RUN: stays in RUN regardless of start_i; only reset leaves RUN.
  - valid_o = (state==RUN), registered.
- Next-PC priority in RUN, evaluated each rising edge:
  1. stall_i=1: pc held, fetch_cnt_o held, branch_i/jump_i ignored, flush_o=0. The stalled ID instruction re-presents its redirect after the stall releases.
  2. jump_i=1: pc <= {id_pc_plus4_i[31:28], jump_addr_i, 2'b00}.
  3. branch_i=1: pc <= id_pc_plus4_i + {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00}. Addition is modulo 2^32, so wrap-around is allowed.
  4. else: pc <= pc_o + PC_STEP, modulo 2^32 (32'hFFFF_FFFC -> 0).
  - jump_i and branch_i both high: jump wins.
- flush_o: combinational = (state==RUN) & ~stall_i & (jump_i | branch_i). Asserted in the same cycle the redirect is accepted, so IF/ID clears the wrong-path fetch at that edge.
- pc_plus4_o: combinational pc_o + PC_STEP, 32-bit wrap.
- fetch_cnt_o: +1 on every RUN edge with stall_i=0 (sequential or redirect). Wraps at 2^32.
- No latency beyond one cycle: a redirect accepted at edge N puts the target on pc_o after edge N.

Test Plan:
- Reset then start_i=1 at cycle 2, no other inputs -> pc_o 0,0,0,4,8,C...; valid_o rises with first PC=0 fetch; fetch_cnt_o counts 1,2,3.
- In RUN at pc_o=0x10, stall_i=1 for 3 cycles -> pc_o stays 0x10, fetch_cnt_o frozen, flush_o=0; release -> 0x14.
- branch_i=1, id_pc_plus4_i=0x0C, branch_imm_i=16'hFFFE -> flush_o=1 that cycle, next pc_o=0x04. branch_imm_i=16'h0003 -> next pc_o=0x18.
- jump_i=1 and branch_i=1 together, id_pc_plus4_i=0xA000_0010, jump_addr_i=26'h0000040 -> next pc_o=0xA000_0100, flush_o=1. Repeat with stall_i=1 -> pc held, flush_o=0.
- PC at 0xFFFF_FFFC sequential -> next pc_o=0x0000_0000; pc_plus4_o at 0xFFFF_FFFC reads 0x0.
- rst_n pulsed low mid-RUN between clock edges at pc_o=0x40 -> pc_o=RESET_PC, valid_o=0, fetch_cnt_o=0 immediately (asynchronous); stays IDLE until start_i.
